// File: rtl/reward_pkg.sv
// reward_pkg -- types and constants shared by the reward packet generator.
//   pkt_type_e : 3-bit on-air packet type codes
//   kind_e     : internal pending-flag index, ordered by send priority
//                (lowest value = highest priority)
//   state_e    : generator FSM states
//   PKT_WORDS  : fixed packet length in words
//   BCAST_ID   : broadcast destination (all ones, sliced to the word width)
package reward_pkg;

  typedef enum logic [2:0] {
    PKT_HB      = 3'b000,
    PKT_MR      = 3'b001,
    PKT_INV     = 3'b010,
    PKT_RSVD    = 3'b011,
    PKT_CHT     = 3'b100,
    PKT_DATA    = 3'b101,
    PKT_SOS     = 3'b110,
    PKT_INVALID = 3'b111
  } pkt_type_e;

  // Pending-flag slots. The enum order is the arbitration order.
  typedef enum logic [2:0] {
    K_HB   = 3'd0,
    K_OINV = 3'd1,
    K_RINV = 3'd2,
    K_MR   = 3'd3,
    K_CHT  = 3'd4,
    K_DATA = 3'd5,
    K_SOS  = 3'd6
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int          NUM_KINDS = 7;
  localparam int          PKT_WORDS = 8;
  localparam logic [63:0] BCAST_ID  = '1;

  // Both INV flavours go out with the same INV type code.
  function automatic pkt_type_e kind_to_type(kind_e k);
    case (k)
      K_HB:           return PKT_HB;
      K_OINV, K_RINV: return PKT_INV;
      K_MR:           return PKT_MR;
      K_CHT:          return PKT_CHT;
      K_DATA:         return PKT_DATA;
      K_SOS:          return PKT_SOS;
      default:        return PKT_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/reward_timer.sv
// reward_timer -- one-shot down-counter used for the MR and CHT deadlines.
//   clk, nrst : clock, asynchronous active-low reset
//   load      : (re)start the count at value; wins over the decrement
//   value     : start count
//   expire    : high in the cycle whose rising edge takes the count 1 -> 0
//   active    : count is non-zero
module reward_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire,
  output logic             active
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign active = (cnt_q != '0);
  assign expire = (cnt_q == WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load)        cnt_d = value;
    else if (active) cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reward_gen.sv
// reward_gen -- builds and streams the 8-word reward/control packets
// (HB, RINV, OINV, MR, CHT, DATA, optional SOS) of a clustering node.
//
// Ports
//   clk, nrst            : clock, asynchronous active-low reset
//   en + f*              : one-cycle strobe qualifying the received packet
//                          type / INV fields
//   iAmDestination, iHaveData, role, low_E : node status inputs
//   myNodeID .. chosenCH : node fields copied into outgoing packets
//   tx_valid/tx_ready    : a word moves when both are high on a rising edge;
//                          while tx_valid is high and tx_ready is low,
//                          tx_word and tx_last stay unchanged
//   tx_last              : marks the 8th word
//   busy                 : FSM not idle
//   reward_done          : one-cycle pulse after the last word moved
//
// Build option: define REWARD_SOS_EN to add the low-energy SOS packet
// (type 110). Without it low_E is ignored.
module reward_gen import reward_pkg::*; #(
  parameter int WORD_WIDTH  = 16,
  parameter int MAX_CH_HOPS = 4,
  parameter int MR_TIMEOUT  = 15,
  parameter int CHT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic                  iAmDestination,
  input  logic                  iHaveData,
  input  logic                  role,
  input  logic                  low_E,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] chosenHop,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic [WORD_WIDTH-1:0] tx_word,
  output logic                  busy,
  output logic                  reward_done
);

  localparam int                    IDX_W    = $clog2(PKT_WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(PKT_WORDS - 1);
  localparam logic [WORD_WIDTH-1:0] BCAST    = BCAST_ID[WORD_WIDTH-1:0];

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_KINDS-1:0]  pend_q, pend_d, set_v, clr_v;
  logic                  hb_lock_q, hb_lock_d;
  logic                  role_q, have_data_q;
  logic [WORD_WIDTH-1:0] rinv_ch_q, rinv_hops_q, rinv_hops_inc;
  kind_e                 sh_kind_q, sel_kind;
  logic [WORD_WIDTH-1:0] pkt_q     [PKT_WORDS];
  logic [WORD_WIDTH-1:0] load_word [PKT_WORDS];
  logic [WORD_WIDTH-1:0] dest_w, ch_id_w, ch_hops_w;
  logic                  rx_hb, rx_inv, rx_data, last_accept;
  logic                  mr_load, mr_expire, mr_active;
  logic                  cht_load, cht_expire, cht_active;

`ifdef REWARD_SOS_EN
  logic low_e_q;
`else
  logic low_e_unused;
  assign low_e_unused = low_E;
`endif

  assign rx_hb   = en && (fPacketType == PKT_HB);
  assign rx_inv  = en && (fPacketType == PKT_INV);
  assign rx_data = en && (fPacketType == PKT_DATA);

  assign rinv_hops_inc = (&fHopsFromCH) ? fHopsFromCH : fHopsFromCH + WORD_WIDTH'(1);

  assign last_accept = (state_q == S_SEND) && tx_ready && (idx_q == LAST_IDX);
  assign mr_load     = rx_inv && !mr_active;
  assign cht_load    = last_accept && (sh_kind_q == K_OINV);

  reward_timer #(.WIDTH(WORD_WIDTH)) u_mr_timer (
    .clk    (clk),
    .nrst   (nrst),
    .load   (mr_load),
    .value  (WORD_WIDTH'(MR_TIMEOUT)),
    .expire (mr_expire),
    .active (mr_active)
  );

  reward_timer #(.WIDTH(WORD_WIDTH)) u_cht_timer (
    .clk    (clk),
    .nrst   (nrst),
    .load   (cht_load),
    .value  (WORD_WIDTH'(CHT_TIMEOUT)),
    .expire (cht_expire),
    .active (cht_active)
  );

  // Trigger detection. A set in the same cycle as the S_LOAD clear wins,
  // so a trigger landing exactly on the load is never lost.
  always_comb begin
    set_v     = '0;
    hb_lock_d = hb_lock_q;
    if (rx_hb)   hb_lock_d = 1'b1;
    if (rx_data) hb_lock_d = 1'b0;
    set_v[K_HB]   = rx_hb && !hb_lock_q;
    set_v[K_DATA] = (rx_data && iAmDestination) || (iHaveData && !have_data_q);
    set_v[K_RINV] = rx_inv && !role && (fHopsFromCH < WORD_WIDTH'(MAX_CH_HOPS));
    set_v[K_OINV] = role && !role_q;
    set_v[K_MR]   = mr_expire;
    set_v[K_CHT]  = cht_expire;
`ifdef REWARD_SOS_EN
    set_v[K_SOS]  = low_E && !low_e_q && !role;
`endif
  end

  // Arbitration: scan from lowest priority up so the highest pending wins.
  always_comb begin
    sel_kind = K_HB;
    for (int i = NUM_KINDS - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_kind = kind_e'(i[2:0]);
    end
    clr_v = '0;
    if (state_q == S_LOAD) clr_v[sel_kind] = 1'b1;
    pend_d = (pend_q & ~clr_v) | set_v;
  end

  // Packet image for the selected type, captured whole at S_LOAD.
  always_comb begin
    case (sel_kind)
      K_HB, K_RINV, K_OINV: dest_w = BCAST;
      K_MR:                 dest_w = chosenCH;
      default:              dest_w = (hopsFromSink == WORD_WIDTH'(1)) ? '0 : chosenHop;
    endcase
    ch_id_w   = chosenCH;
    ch_hops_w = '0;
    if (sel_kind == K_OINV) begin
      ch_id_w   = myNodeID;
      ch_hops_w = WORD_WIDTH'(1);
    end else if (sel_kind == K_RINV) begin
      ch_id_w   = rinv_ch_q;
      ch_hops_w = rinv_hops_q;
    end
    load_word[0] = {{(WORD_WIDTH-3){1'b0}}, kind_to_type(sel_kind)};
    load_word[1] = myNodeID;
    load_word[2] = dest_w;
    load_word[3] = myEnergy;
    load_word[4] = myQValue;
    load_word[5] = hopsFromSink;
    load_word[6] = ch_id_w;
    load_word[7] = ch_hops_w;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (|pend_q) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_SEND;
        idx_d   = '0;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pend_q      <= '0;
      hb_lock_q   <= 1'b0;
      role_q      <= 1'b0;
      have_data_q <= 1'b0;
      rinv_ch_q   <= '0;
      rinv_hops_q <= '0;
      sh_kind_q   <= K_HB;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      hb_lock_q   <= hb_lock_d;
      role_q      <= role;
      have_data_q <= iHaveData;
      // Coalesced RINV triggers keep the most recent INV fields.
      if (set_v[K_RINV]) begin
        rinv_ch_q   <= fChosenCH;
        rinv_hops_q <= rinv_hops_inc;
      end
      if (state_q == S_LOAD) sh_kind_q <= sel_kind;
    end
  end

`ifdef REWARD_SOS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) low_e_q <= 1'b0;
    else       low_e_q <= low_E;
  end
`endif

  // Data-only storage: visibility is gated by the FSM state, which resets.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int i = 0; i < PKT_WORDS; i++) pkt_q[i] <= load_word[i];
    end
  end

  assign tx_valid    = (state_q == S_SEND);
  assign tx_last     = tx_valid && (idx_q == LAST_IDX);
  assign tx_word     = tx_valid ? pkt_q[idx_q] : '0;
  assign busy        = (state_q != S_IDLE);
  assign reward_done = (state_q == S_DONE);

endmodule

// File: tb/tb_reward_gen.sv
module tb_reward_gen;

  localparam int W = 16;

  localparam int M_HB   = 0;
  localparam int M_RINV = 1;
  localparam int M_OINV = 2;
  localparam int M_MR   = 3;
  localparam int M_CHT  = 4;
  localparam int M_DATA = 5;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   fPacketType = 3'b111;
  logic [W-1:0] fHopsFromCH = '0;
  logic [W-1:0] fChosenCH = '0;
  logic         iAmDestination = 1'b0;
  logic         iHaveData = 1'b0;
  logic         role = 1'b0;
  logic         low_E = 1'b0;
  logic [W-1:0] myNodeID = 16'h0011;
  logic [W-1:0] myEnergy = 16'h0022;
  logic [W-1:0] myQValue = 16'h0033;
  logic [W-1:0] hopsFromSink = 16'h0004;
  logic [W-1:0] chosenHop = 16'h0055;
  logic [W-1:0] chosenCH = 16'h0066;
  logic         tx_ready = 1'b1;
  logic         tx_valid, tx_last, busy, reward_done;
  logic [W-1:0] tx_word;

  reward_gen dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .fPacketType    (fPacketType),
    .fHopsFromCH    (fHopsFromCH),
    .fChosenCH      (fChosenCH),
    .iAmDestination (iAmDestination),
    .iHaveData      (iHaveData),
    .role           (role),
    .low_E          (low_E),
    .myNodeID       (myNodeID),
    .myEnergy       (myEnergy),
    .myQValue       (myQValue),
    .hopsFromSink   (hopsFromSink),
    .chosenHop      (chosenHop),
    .chosenCH       (chosenCH),
    .tx_ready       (tx_ready),
    .tx_valid       (tx_valid),
    .tx_last        (tx_last),
    .tx_word        (tx_word),
    .busy           (busy),
    .reward_done    (reward_done)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int exp_dones = 0;
  int done_cnt = 0;
  int widx = 0;
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: the packet word a given packet kind carries, derived
  // straight from the field rules using the current node inputs.
  function automatic logic [W-1:0] ref_word(input int kind, input int idx,
                                            input logic [W-1:0] cap_ch,
                                            input logic [W-1:0] cap_hops);
    logic [W-1:0] code, dest, chid, chh;
    case (kind)
      M_HB:           code = 16'd0;
      M_RINV, M_OINV: code = 16'd2;
      M_MR:           code = 16'd1;
      M_CHT:          code = 16'd4;
      default:        code = 16'd5;
    endcase
    if (kind == M_HB || kind == M_RINV || kind == M_OINV) dest = 16'hFFFF;
    else if (kind == M_MR)                               dest = chosenCH;
    else                                                 dest = (hopsFromSink == 16'd1) ? 16'd0 : chosenHop;
    chid = chosenCH;
    chh  = 16'd0;
    if (kind == M_OINV) begin
      chid = myNodeID;
      chh  = 16'd1;
    end else if (kind == M_RINV) begin
      chid = cap_ch;
      chh  = (cap_hops == 16'hFFFF) ? cap_hops : cap_hops + 16'd1;
    end
    case (idx)
      0:       return code;
      1:       return myNodeID;
      2:       return dest;
      3:       return myEnergy;
      4:       return myQValue;
      5:       return hopsFromSink;
      6:       return chid;
      default: return chh;
    endcase
  endfunction

  task automatic push_pkt(input int kind, input logic [W-1:0] cap_ch, input logic [W-1:0] cap_hops);
    for (int i = 0; i < 8; i++) exp_q.push_back(ref_word(kind, i, cap_ch, cap_hops));
    exp_dones++;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] held_word;
    logic [W-1:0] exp_w;
    bit stalled;
    stalled = 1'b0;
    held_word = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        widx = 0;
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid_held", {15'd0, tx_valid}, 16'd1);
          check("stall_word_held", tx_word, held_word);
        end
        stalled = tx_valid && !tx_ready;
        held_word = tx_word;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_word: got %h expected none (cycle %0d)", tx_word, cyc);
          end else begin
            exp_w = exp_q.pop_front();
            check($sformatf("word%0d", widx), tx_word, exp_w);
            check("tx_last", {15'd0, tx_last}, {15'd0, (widx == 7)});
            widx = (widx + 1) % 8;
          end
        end
        if (reward_done) done_cnt++;
      end
    end
  end

  // tx_ready: held high, or randomised each cycle during stall tests.
  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulses en for one cycle; returns the cycle number of the sampling edge.
  task automatic send_en(input logic [2:0] ptype, input logic [W-1:0] hops,
                         input logic [W-1:0] ch, output int t_edge);
    en = 1'b1;
    fPacketType = ptype;
    fHopsFromCH = hops;
    fChosenCH = ch;
    t_edge = cyc + 1;
    tick();
    en = 1'b0;
    fPacketType = 3'b111;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (reward_done) begin
        found = 1'b1;
        if (exp_cyc >= 0) check(name, W'(cyc), W'(exp_cyc));
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s: got no reward_done expected one within 400 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s: got busy=%0d pending_words=%0d expected idle", name, busy, exp_q.size());
    end
  endtask

  task automatic randomize_fields(input logic [W-1:0] sink_hops);
    myNodeID     = W'($urandom_range(1, 16'hFFFE));
    myEnergy     = W'($urandom);
    myQValue     = W'($urandom);
    chosenHop    = W'($urandom_range(1, 16'hFFFE));
    chosenCH     = W'($urandom_range(1, 16'hFFFE));
    hopsFromSink = sink_hops;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t2, done_before;
    bit busy_seen;
    logic [W-1:0] inv_ch, inv_hops;
    logic [2:0] ign_types [4];
    ign_types[0] = 3'b001;
    ign_types[1] = 3'b011;
    ign_types[2] = 3'b100;
    ign_types[3] = 3'b111;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("rst_tx_last", {15'd0, tx_last}, 16'd0);
    check("rst_tx_word", tx_word, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_reward_done", {15'd0, reward_done}, 16'd0);
    tick();
    nrst = 1'b1;
    repeat (2) tick();

    // HB: one packet, done on the 11th cycle; a second HB is locked out.
    randomize_fields(W'($urandom_range(2, 9)));
    push_pkt(M_HB, '0, '0);
    send_en(3'b000, '0, '0, t);
    wait_done("hb_done_cycle", t + 10);
    wait_idle("hb_idle");
    tick();
    send_en(3'b000, '0, '0, t);
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("hb_lock_no_packet", {15'd0, busy_seen}, 16'd0);
    tick();

    // INV below the hop limit: RINV now, MR 15 cycles after the INV.
    randomize_fields(W'($urandom_range(2, 9)));
    inv_ch = W'($urandom_range(1, 16'hFFFE));
    inv_hops = W'($urandom_range(0, 3));
    push_pkt(M_RINV, inv_ch, inv_hops);
    push_pkt(M_MR, '0, '0);
    send_en(3'b010, inv_hops, inv_ch, t);
    wait_done("rinv_done_cycle", t + 10);
    wait_done("mr_done_cycle", t + 25);
    wait_idle("rinv_mr_idle");
    tick();

    // INV at the hop limit: no RINV, MR timer still runs. Ignored packet
    // types in between must not disturb anything.
    randomize_fields(W'($urandom_range(2, 9)));
    push_pkt(M_MR, '0, '0);
    send_en(3'b010, 16'd4, W'($urandom), t);
    for (int i = 0; i < 4; i++) send_en(ign_types[$urandom_range(0, 3)], W'($urandom_range(0, 3)), W'($urandom), t2);
`ifndef REWARD_SOS_EN
    low_E = 1'b1;
    tick();
    low_E = 1'b0;
`endif
    wait_done("mr_only_done_cycle", t + 25);
    wait_idle("mr_only_idle");
    tick();

    // Role rises: OINV, then CHT 15 cycles after the OINV completes.
    randomize_fields(W'($urandom_range(2, 9)));
    push_pkt(M_OINV, '0, '0);
    push_pkt(M_CHT, '0, '0);
    role = 1'b1;
    t = cyc + 1;
    tick();
    wait_done("oinv_done_cycle", t + 10);
    wait_done("cht_done_cycle", t + 35);
    wait_idle("oinv_cht_idle");
    role = 1'b0;
    tick();

    // DATA and HB arrive while busy, tx_ready toggling: HB goes first.
    randomize_fields(16'd1);
    iAmDestination = 1'b1;
    rdy_rand = 1'b1;
    push_pkt(M_DATA, '0, '0);
    send_en(3'b101, '0, '0, t);
    repeat (3) tick();
    iHaveData = 1'b1;
    tick();
    push_pkt(M_HB, '0, '0);
    push_pkt(M_DATA, '0, '0);
    send_en(3'b000, '0, '0, t);
    check("busy_while_triggers", {15'd0, busy}, 16'd1);
    wait_done("stall_done_1", -1);
    wait_done("stall_done_2", -1);
    wait_done("stall_done_3", -1);
    rdy_rand = 1'b0;
    wait_idle("stall_idle");
    iAmDestination = 1'b0;
    iHaveData = 1'b0;
    tick();

    // Reset at word 4 of an HB with a DATA pending and the MR timer running.
    randomize_fields(W'($urandom_range(2, 9)));
    send_en(3'b101, '0, '0, t);
    send_en(3'b010, 16'd5, W'($urandom), t);
    push_pkt(M_HB, '0, '0);
    send_en(3'b000, '0, '0, t);
    iHaveData = 1'b1;
    tick();
    iHaveData = 1'b0;
    for (int i = 0; i < 20 && cyc < t + 5; i++) tick();
    check("pre_reset_valid", {15'd0, tx_valid}, 16'd1);
    check("pre_reset_word3", tx_word, ref_word(M_HB, 3, '0, '0));
    done_before = done_cnt;
    nrst = 1'b0;
    #1;
    check("mid_rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("mid_rst_tx_last", {15'd0, tx_last}, 16'd0);
    check("mid_rst_tx_word", tx_word, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_reward_done", {15'd0, reward_done}, 16'd0);
    exp_q.delete();
    exp_dones--;
    repeat (3) tick();
    nrst = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("post_rst_no_packet", {15'd0, busy_seen}, 16'd0);
    check("post_rst_no_done", W'(done_cnt), W'(done_before));

    // Final bookkeeping
    check("left_over_words", W'(exp_q.size()), 16'd0);
    check("reward_done_count", W'(done_cnt), W'(exp_dones));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reward_gen.md
REWARD_GEN -- requirements
Module: reward_gen

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, width of every ID, hop, energy and Q field and of tx_word.
REQ-002 SHALL have parameter MAX_CH_HOPS, default 4; an INV is rippled only if its hopsFromCH is below this value.
REQ-003 SHALL have parameter MR_TIMEOUT, default 15, the number of cycles from the first INV received to the MR send.
REQ-004 SHALL have parameter CHT_TIMEOUT, default 15, the number of cycles from the own-INV send to the CHT send.
REQ-005 SHALL have port clk, input, 1 bit: the only clock, all state updates on its rising edge.
REQ-006 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: one-cycle strobe meaning the filtered fields below are valid this cycle.
REQ-008 SHALL have port fPacketType, input, 3 bits: the received packet type.
REQ-009 SHALL have ports fHopsFromCH and fChosenCH, input, WORD_WIDTH each: the received INV fields.
REQ-010 SHALL have ports iAmDestination, iHaveData, role and low_E, input, 1 bit each.
REQ-011 SHALL have ports myNodeID, myEnergy, myQValue, hopsFromSink, chosenHop and chosenCH, input, WORD_WIDTH each.
REQ-012 SHALL have port tx_ready, input, 1 bit: the downstream transmitter accepts a word.
REQ-013 SHALL have ports tx_valid and tx_last, output, 1 bit each.
REQ-014 SHALL have port tx_word, output, WORD_WIDTH: the current packet word.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not in S_IDLE.
REQ-016 SHALL have port reward_done, output, 1 bit: one-cycle pulse when a packet completes.

Function
REQ-017 SHALL keep one pending flag per packet type: HB, RINV, OINV, MR, CHT, DATA, SOS.
- Priority, highest first: HB > OINV > RINV > MR > CHT > DATA > SOS.
REQ-018 SHALL, on en with fPacketType 000 and HBLock=0: set pend_HB and HBLock.
- The same with HBLock=1: ignore it.
REQ-019 SHALL, on en with fPacketType 101: clear HBLock.
- If iAmDestination is also set: set pend_DATA.
REQ-020 SHALL, on en with fPacketType 010, role=0 and fHopsFromCH < MAX_CH_HOPS: set pend_RINV.
- Capture fChosenCH and fHopsFromCH+1, saturating at all-ones.
REQ-021 SHALL load the MR timer with MR_TIMEOUT on the first INV received while the timer is idle.
- Decrement once per cycle; on 1->0 set pend_MR and return the timer to idle.
REQ-022 SHALL set pend_OINV on the rising edge of role.
- Completing the OINV send loads the CHT timer with CHT_TIMEOUT; its expiry sets pend_CHT.
REQ-023 SHALL set pend_DATA on the rising edge of iHaveData.
REQ-024 SHALL define the FSM as follows:
- S_IDLE -> S_LOAD when any pending flag is set.
- S_LOAD: latch the highest-priority type into the shadow fields and clear its flag.
- S_LOAD -> S_SEND.
- S_SEND -> S_DONE after the word with tx_last is accepted.
- S_DONE -> S_IDLE, pulsing reward_done.
REQ-025 SHALL send a fixed 8-word packet, one word per tx_valid&&tx_ready.
- Word order: type (zero-extended), myNodeID, destination, myEnergy, myQValue, hopsFromSink, CH ID, hopsFromCH.
- tx_last is high on word 8.
REQ-026 SHALL set the destination as follows:
- HB, RINV and OINV: all-ones.
- MR: chosenCH.
- Otherwise: 0 if hopsFromSink==1, else chosenHop.
REQ-027 SHALL set the CH ID and hopsFromCH words as follows:
- OINV: myNodeID and 1.
- RINV: the captured values.
- Otherwise: chosenCH and 0.
REQ-028 SHALL hold tx_word and tx_valid stable while tx_ready=0.
REQ-029 SHALL take the minimum latency of 11 cycles from pend set to reward_done with tx_ready held at 1.
REQ-030 SHALL set a newly triggered flag even while busy.
- A trigger for an already-pending type coalesces into it; RINV keeps the latest captured fields.
REQ-031 SHALL apply a flag set and a same-cycle clear (S_LOAD) of the same type as set-wins.
REQ-032 SHALL be unaffected by en when fPacketType is 001, 011, 100 or 111.

Reset
REQ-033 SHALL set the following while nrst is low, asynchronously:
- tx_valid=0, tx_last=0, tx_word=0, busy=0, reward_done=0.
- All flags, HBLock and timers cleared; FSM in S_IDLE.
REQ-034 SHALL, if reset is asserted mid-packet, drop the packet without completing it and without pulsing reward_done.

Configuration
REQ-035 SHALL, with REWARD_SOS_EN defined, set pend_SOS on the rising edge of low_E while role=0, sending packet type 110.
- Without it: no SOS logic exists and low_E is ignored.

Structure
REQ-036 SHALL place the packet-type enum (HB=000 ... SOS=110, INVALID=111), the broadcast ID constant and PKT_WORDS=8 in the shared package reward_pkg.
REQ-037 SHALL implement the MR and CHT timers as two instances of sub-module reward_timer, each with ports load, value, expire and active.

Verification
REQ-038 SHALL cover: en with HB, tx_ready=1 -> 8 words with word0=0 and word2=FFFF; reward_done on cycle 11; a second HB gives no packet.
REQ-039 SHALL cover: INV with fHopsFromCH=2 -> RINV sent with word7=3; after 15 further cycles an MR is sent with word2=chosenCH.
REQ-040 SHALL cover: INV with fHopsFromCH=4 -> no RINV; the MR timer still starts.
REQ-041 SHALL cover: role rises -> OINV with word6=myNodeID and word7=1; a CHT (type 100) follows 15 cycles after its reward_done.
REQ-042 SHALL cover: a DATA and an HB arriving while busy with tx_ready toggling -> HB is sent before DATA; tx_word is stable while stalled; DATA has word2=0 when hopsFromSink=1.
REQ-043 SHALL cover: nrst pulsed at word 4 -> outputs are zero immediately; no reward_done; no pending flags remain after release.
